// File: rtl/spi_command_master.sv
// spi_command_master: host-side SPI mode-0 controller that sends one fixed
// 8-byte command frame (instruction, address, value) per handshake, MSB first,
// and returns the last four POCI bytes of the frame as a 32-bit result.
module spi_command_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        ready_o,
    input  logic [7:0]  instruction_i,
    input  logic [23:0] address_i,
    input  logic [31:0] value_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        spi_sclk_o,
    output logic        spi_pico_o,
    input  logic        spi_poci_i,
    output logic        spi_cs_o
);

    localparam int unsigned FRAME_W  = 64;
    localparam int unsigned RESULT_W = 32;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned BIT_W    = 3;

    // Terminal counts for the shared divider/gap counter.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam bit               GAP_EN   = (GAP_CYCLES != 0);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] tx_sr;
    logic [RESULT_W-1:0] rx_sr;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   byte_cnt;

    // Frame sequencer: divider, bit/byte counters, shift registers and all SPI/handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            spi_cs_o   <= 1'b1;
            spi_sclk_o <= 1'b0;
            spi_pico_o <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && ready_o) begin
                        tx_sr      <= {instruction_i, address_i, value_i};
                        spi_pico_o <= instruction_i[7];
                        spi_cs_o   <= 1'b0;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        div_cnt    <= '0;
                        state      <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sclk_o) begin
                            // Rising SCLK: capture responder data.
                            spi_sclk_o <= 1'b1;
                            rx_sr      <= {rx_sr[RESULT_W-2:0], spi_poci_i};
                        end else begin
                            // Falling SCLK: present the next transmit bit.
                            spi_sclk_o <= 1'b0;
                            tx_sr      <= {tx_sr[FRAME_W-2:0], 1'b0};
                            spi_pico_o <= tx_sr[FRAME_W-2];
                            if (bit_cnt != LAST_IDX) begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end else begin
                                bit_cnt <= '0;
                                if (byte_cnt == LAST_IDX) begin
                                    byte_cnt <= '0;
                                    state    <= S_HOLD;
                                end else begin
                                    byte_cnt <= byte_cnt + BIT_W'(1);
                                    state    <= GAP_EN ? S_GAP : S_SHIFT;
                                end
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                S_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_cs_o <= 1'b1;
                        result_o <= rx_sr;
                        done_o   <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_command_master.sv
// tb_spi_command_master: directed bench with a cycle-level timing model of the
// frame for two instances (default divider/gap, and CLK_DIV=1/GAP_CYCLES=0).
module tb_spi_command_master;

    localparam int DA = 4;
    localparam int GA = 2;
    localparam int LA = DA + 128*DA + 7*GA + DA;   // 534
    localparam int DB = 1;
    localparam int GB = 0;
    localparam int LB = DB + 128*DB + 7*GB + DB;   // 130
    localparam logic [63:0] RSP       = 64'h0001020304050607;
    localparam logic [31:0] RSP_LAST4 = 32'h04050607;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 1'b0;
    logic [7:0]  instr_a = '0;
    logic [23:0] addr_a  = '0;
    logic [31:0] value_a = '0;
    logic        ready_a, done_a, busy_a, sclk_a, pico_a, poci_a, cs_a;
    logic [31:0] result_a;

    logic        start_b = 1'b0;
    logic [7:0]  instr_b = '0;
    logic [23:0] addr_b  = '0;
    logic [31:0] value_b = '0;
    logic        ready_b, done_b, busy_b, sclk_b, pico_b, poci_b, cs_b;
    logic [31:0] result_b;

    logic        mode_a = 1'b0;      // 0: loopback, 1: responder returning bytes 00..07
    logic [63:0] rsp_sr = RSP;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    spi_command_master #(.CLK_DIV(DA), .GAP_CYCLES(GA)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .ready_o(ready_a),
        .instruction_i(instr_a), .address_i(addr_a), .value_i(value_a),
        .result_o(result_a), .done_o(done_a), .busy_o(busy_a),
        .spi_sclk_o(sclk_a), .spi_pico_o(pico_a), .spi_poci_i(poci_a), .spi_cs_o(cs_a)
    );

    spi_command_master #(.CLK_DIV(DB), .GAP_CYCLES(GB)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .ready_o(ready_b),
        .instruction_i(instr_b), .address_i(addr_b), .value_i(value_b),
        .result_o(result_b), .done_o(done_b), .busy_o(busy_b),
        .spi_sclk_o(sclk_b), .spi_pico_o(pico_b), .spi_poci_i(poci_b), .spi_cs_o(cs_b)
    );

    // Mode-0 responder: first bit valid at CS fall, next bit after each falling SCLK.
    always @(negedge sclk_a or posedge cs_a) begin
        if (cs_a !== 1'b0) rsp_sr <= RSP;
        else               rsp_sr <= {rsp_sr[62:0], 1'b0};
    end

    assign poci_a = mode_a ? rsp_sr[63] : pico_a;
    assign poci_b = pico_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected {ready,busy,done,cs,sclk,pico} in cycle k after the handshake cycle.
    function automatic logic [5:0] expv(input int d, input int g, input int k, input logic [63:0] f);
        int l, s, per, b, p, idx;
        logic sc, pi;
        l = d + 128*d + 7*g + d;
        if (k < 1 || k >= l + 2) return 6'b100100;
        if (k == l + 1)          return 6'b011100;
        if (k <= d)              return {4'b0100, 1'b0, f[63]};
        s = k - d - 1;
        if (s >= 128*d + 7*g)    return 6'b010000;
        per = 16*d + g;
        b   = s / per;
        p   = s % per;
        if (p >= 16*d) begin
            idx = 8*(b + 1);
            sc  = 1'b0;
        end else begin
            idx = 8*b + p / (2*d);
            sc  = ((p % (2*d)) >= d);
        end
        pi = (idx < 64) ? f[63 - idx] : 1'b0;
        return {4'b0100, sc, pi};
    endfunction

    // Model state: handshake cycle of the frame in flight, its frame and the result it yields.
    int          a_acc   = -1;
    logic [63:0] a_frame = '0;
    logic        a_mode  = 1'b0;
    logic [31:0] a_res   = '0;
    int          b_acc   = -1;
    logic [63:0] b_frame = '0;
    logic [31:0] b_res   = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            a_acc <= -1;
            a_res <= '0;
            b_acc <= -1;
            b_res <= '0;
        end else begin
            if (a_acc >= 0 && (cyc + 1) - a_acc == LA + 1)
                a_res <= a_mode ? RSP_LAST4 : a_frame[31:0];
            if (start_a && (a_acc < 0 || cyc - a_acc >= LA + 2)) begin
                a_acc   <= cyc;
                a_frame <= {instr_a, addr_a, value_a};
                a_mode  <= mode_a;
            end
            if (b_acc >= 0 && (cyc + 1) - b_acc == LB + 1)
                b_res <= b_frame[31:0];
            if (start_b && (b_acc < 0 || cyc - b_acc >= LB + 2)) begin
                b_acc   <= cyc;
                b_frame <= {instr_b, addr_b, value_b};
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("a_pins", 64'({ready_a, busy_a, done_a, cs_a, sclk_a, pico_a}),
                64'(expv(DA, GA, (a_acc < 0) ? -1 : cyc - a_acc, a_frame)));
            chk("a_result", 64'(result_a), 64'(a_res));
            chk("b_pins", 64'({ready_b, busy_b, done_b, cs_b, sclk_b, pico_b}),
                64'(expv(DB, GB, (b_acc < 0) ? -1 : cyc - b_acc, b_frame)));
            chk("b_result", 64'(result_b), 64'(b_res));
        end
    end

    task automatic launch_a(input logic [7:0] i, input logic [23:0] a, input logic [31:0] v, output int t0);
        @(negedge clk);
        instr_a = i;
        addr_a  = a;
        value_a = v;
        start_a = 1'b1;
        t0      = cyc;
    endtask

    task automatic observe_a(input int t0, input int n, input bit hold,
                             output logic [63:0] cap, output int rises, output int dcnt,
                             output int dat, output int csl, output int fl);
        logic prev;
        int   k;
        prev = 1'b0;
        cap = '0; rises = 0; dcnt = 0; dat = -1; csl = 0; fl = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold && i == 0) start_a = 1'b0;
            k = cyc - t0;
            if (sclk_a && !prev) begin
                cap = {cap[62:0], pico_a};
                rises++;
            end
            prev = sclk_a;
            if (done_a) begin
                dcnt++;
                dat = k;
            end
            if (!cs_a) begin
                if (k >= 1 && k <= LA) csl++;
                if (fl < 0) fl = k;
            end
        end
    endtask

    logic [63:0] cap;
    int rises, dcnt, dat, csl, fl, t0, t1;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready_a), 64'd1);
        chk("reset_cs", 64'(cs_a), 64'd1);
        chk("reset_result", 64'(result_a), 64'd0);
        rst = 1'b0;

        // Loopback with defaults; a busy start pulse and input churn must be ignored.
        launch_a(8'hA5, 24'h123456, 32'hDEADBEEF, t0);
        fork
            observe_a(t0, 540, 1'b0, cap, rises, dcnt, dat, csl, fl);
            begin
                repeat (50) @(negedge clk);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                repeat (9) @(negedge clk);
                instr_a = 8'hFF; addr_a = 24'h000000; value_a = 32'h55555555;
            end
        join
        chk("lb_pico_frame", cap, 64'hA5123456DEADBEEF);
        chk("lb_result", 64'(result_a), 64'h00000000DEADBEEF);
        chk("lb_done_count", 64'(dcnt), 64'd1);
        chk("lb_done_cycle", 64'(dat), 64'd535);

        // Responder returning bytes 00..07.
        mode_a = 1'b1;
        launch_a(8'hC3, 24'hABCDEF, 32'h11223344, t0);
        observe_a(t0, 540, 1'b0, cap, rises, dcnt, dat, csl, fl);
        chk("rsp_result", 64'(result_a), 64'h0000000004050607);
        chk("rsp_pico_frame", cap, 64'hC3ABCDEF11223344);
        chk("rsp_sclk_rises", 64'(rises), 64'd64);
        chk("rsp_cs_low_cycles", 64'(csl), 64'd534);
        chk("rsp_cs_first_low", 64'(fl), 64'd1);
        chk("rsp_done_cycle", 64'(dat), 64'd535);
        mode_a = 1'b0;

        // Back-to-back with start held; inputs change mid-frame to the next command.
        launch_a(8'h5A, 24'h0A0B0C, 32'h01020304, t0);
        fork
            observe_a(t0, 536, 1'b1, cap, rises, dcnt, dat, csl, fl);
            begin
                repeat (100) @(negedge clk);
                instr_a = 8'h3C; addr_a = 24'h778899; value_a = 32'hCAFEF00D;
            end
        join
        chk("b2b_first_frame", cap, 64'h5A0A0B0C01020304);
        chk("b2b_first_done", 64'(dat), 64'd535);
        t1 = t0 + 536;
        observe_a(t1, 540, 1'b0, cap, rises, dcnt, dat, csl, fl);
        chk("b2b_second_accept", 64'(fl), 64'd1);
        chk("b2b_second_frame", cap, 64'h3C778899CAFEF00D);
        chk("b2b_second_result", 64'(result_a), 64'h00000000CAFEF00D);
        chk("b2b_second_done", 64'(dat), 64'd535);

        // Reset in cycle 200 of a frame, then a clean command.
        launch_a(8'h96, 24'h445566, 32'h0BADF00D, t0);
        observe_a(t0, 200, 1'b0, cap, rises, dcnt, dat, csl, fl);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cs", 64'(cs_a), 64'd1);
        chk("rst_sclk", 64'(sclk_a), 64'd0);
        chk("rst_ready", 64'(ready_a), 64'd1);
        chk("rst_result", 64'(result_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        launch_a(8'hE7, 24'h010203, 32'h76543210, t0);
        observe_a(t0, 540, 1'b0, cap, rises, dcnt, dat, csl, fl);
        chk("post_rst_result", 64'(result_a), 64'h0000000076543210);
        chk("post_rst_done", 64'(dat), 64'd535);

        // Boundary instance: CLK_DIV=1, GAP_CYCLES=0.
        @(negedge clk);
        instr_b = 8'h00; addr_b = 24'h000000; value_b = 32'h80000001;
        start_b = 1'b1;
        t0 = cyc;
        begin
            logic prev;
            int   k, tog, bdat, bcsl;
            prev = 1'b0; tog = 0; bdat = -1; bcsl = 0;
            for (int i = 0; i < 140; i++) begin
                @(negedge clk);
                if (i == 0) start_b = 1'b0;
                k = cyc - t0;
                if (sclk_b != prev) tog++;
                prev = sclk_b;
                if (done_b) bdat = k;
                if (!cs_b && k >= 1 && k <= LB) bcsl++;
            end
            chk("div1_done_cycle", 64'(bdat), 64'd131);
            chk("div1_sclk_toggles", 64'(tog), 64'd128);
            chk("div1_cs_low_cycles", 64'(bcsl), 64'd130);
            chk("div1_result", 64'(result_b), 64'h0000000080000001);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
